// File: rtl/riscv_fetch_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry circular buffer with valid/ready on both sides.
// The head payload reads as all-zero whenever the queue is empty, matching a flushed F/D register.
module riscv_fetch_queue #(
    parameter  int XLEN  = 64,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic            i_riscv_fq_clk,
    input  logic            i_riscv_fq_rst_n,
    input  logic            i_riscv_fq_flush,
    input  logic            i_riscv_fq_valid_f,
    output logic            o_riscv_fq_ready_f,
    input  logic [XLEN-1:0] i_riscv_fq_pc_f,
    input  logic [31:0]     i_riscv_fq_inst_f,
    input  logic [XLEN-1:0] i_riscv_fq_pcplus4_f,
    input  logic            i_riscv_fq_cillegal_inst_f,
    input  logic [15:0]     i_riscv_fq_cinst_f,
    output logic            o_riscv_fq_valid_d,
    input  logic            i_riscv_fq_ready_d,
    output logic [XLEN-1:0] o_riscv_fq_pc_d,
    output logic [31:0]     o_riscv_fq_inst_d,
    output logic [XLEN-1:0] o_riscv_fq_pcplus4_d,
    output logic            o_riscv_fq_cillegal_inst_d,
    output logic [15:0]     o_riscv_fq_cinst_d,
    output logic [4:0]      o_riscv_fq_rs1_d,
    output logic [11:0]     o_riscv_fq_constimm12_d,
    output logic [CW-1:0]   o_riscv_fq_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [XLEN-1:0] pcplus4;
        logic            cillegal;
        logic [15:0]     cinst;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;

    // Handshake depends only on registered occupancy, so ready_f never follows ready_d.
    assign o_riscv_fq_ready_f = (count != FULL);
    assign o_riscv_fq_valid_d = (count != '0);
    assign push = i_riscv_fq_valid_f & o_riscv_fq_ready_f;
    assign pop  = o_riscv_fq_valid_d & i_riscv_fq_ready_d;
    assign o_riscv_fq_count = count;

    always_ff @(posedge i_riscv_fq_clk) begin
        if (!i_riscv_fq_rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (i_riscv_fq_flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not cleared; stale entries are hidden by the empty mask on the head.
    always_ff @(posedge i_riscv_fq_clk) begin
        if (push) begin
            mem[wptr] <= '{pc:       i_riscv_fq_pc_f,
                           inst:     i_riscv_fq_inst_f,
                           pcplus4:  i_riscv_fq_pcplus4_f,
                           cillegal: i_riscv_fq_cillegal_inst_f,
                           cinst:    i_riscv_fq_cinst_f};
        end
    end

    always_comb begin
        head = '0;
        if (count != '0) begin
            head = mem[rptr];
        end
    end

    assign o_riscv_fq_pc_d            = head.pc;
    assign o_riscv_fq_inst_d          = head.inst;
    assign o_riscv_fq_pcplus4_d       = head.pcplus4;
    assign o_riscv_fq_cillegal_inst_d = head.cillegal;
    assign o_riscv_fq_cinst_d         = head.cinst;
    assign o_riscv_fq_rs1_d           = head.inst[19:15];
    assign o_riscv_fq_constimm12_d    = head.inst[31:20];

endmodule

// File: doc/riscv_fetch_queue.md
# riscv_fetch_queue

Parametrised fetch-to-decode instruction queue: the next-generation F/D boundary element, replacing the single-entry stall/flush register. It buffers up to DEPTH fetched instructions with a valid/ready handshake on both sides, so fetch keeps running while decode stalls. Each entry carries the fetch bundle (PC, instruction, PC+4, compressed-instruction info), and the head presents pre-extracted rs1 and 12-bit immediate fields to decode. Sits between the fetch stage/compressed decoder and the decode stage; flushed on redirect.

## Interface
- XLEN, 64, PC width in bits.
- DEPTH, 4, number of entries; power of two, >= 2.
- CW, $clog2(DEPTH+1), occupancy counter width (derived, not overridden).

- i_riscv_fq_clk  in  1  clock; all state updates on rising edge.
- i_riscv_fq_rst_n  in  1  reset, synchronous, active-low.
- i_riscv_fq_flush  in  1  synchronous flush; empties queue.
- i_riscv_fq_valid_f  in  1  fetch presents an entry.
- o_riscv_fq_ready_f  out  1  queue can accept an entry.
- i_riscv_fq_pc_f  in  XLEN  PC of fetched instruction.
- i_riscv_fq_inst_f  in  32  expanded instruction.
- i_riscv_fq_pcplus4_f  in  XLEN  next sequential PC.
- i_riscv_fq_cillegal_inst_f  in  1  illegal compressed instruction flag.
- i_riscv_fq_cinst_f  in  16  original compressed encoding.
- o_riscv_fq_valid_d  out  1  head entry valid.
- i_riscv_fq_ready_d  in  1  decode consumes head this cycle.
- o_riscv_fq_pc_d / o_riscv_fq_inst_d / o_riscv_fq_pcplus4_d  out  XLEN/32/XLEN  head payload.
- o_riscv_fq_cillegal_inst_d  out  1  head cillegal flag.
- o_riscv_fq_cinst_d  out  16  head compressed encoding.
- o_riscv_fq_rs1_d  out  5  head inst[19:15].
- o_riscv_fq_constimm12_d  out  12  head inst[31:20].
- o_riscv_fq_count  out  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH-entry circular buffer; write pointer, read pointer (log2(DEPTH) bits, natural wrap), registered count.
- push = valid_f & ready_f; pop = valid_d & ready_d.
- ready_f = (count != DEPTH); depends only on registered state, never on ready_d (no full-cycle pass-through).
- valid_d = (count != 0).
- Push: write bundle at wptr, wptr+1. Pop: rptr+1. count += push - pop; push and pop together leave count unchanged.
- Head outputs are read combinationally from entry[rptr]; rs1/imm12 sliced from stored inst. When count == 0 all payload outputs are forced to 0 (bubble identical to a flushed register).
- Priority per edge: reset > flush > push/pop.
- Flush: rptr, wptr, count -> 0; a push or pop in the same cycle is discarded. Entry storage need not be cleared (masked by empty).
- Reset (rst_n low at edge): pointers and count -> 0; therefore valid_d=0, ready_f=1, all payload outputs 0, count 0.
- No fall-through: an entry pushed into an empty queue is not visible to decode in the same cycle.

## Timing
- Latency fetch -> decode: 1 cycle (push at edge N, valid_d high from edge N until popped).
- Throughput: 1 entry/cycle sustained when ready_d held high.
- Full with pop: ready_f stays 0 that cycle; frees a slot next cycle.
- Empty: ready_d ignored; no pointer movement.
- Flush asserted while rst_n high: outputs reflect empty state the cycle after the edge.
- Reset mid-operation: all queued entries lost, same post-state as flush.
- Pointer wrap at DEPTH-1 -> 0 is transparent to ordering.

## Test plan
- Reset: rst_n=0 one edge with valid_f=1 -> count=0, valid_d=0, ready_f=1, pc_d=0, inst_d=0.
- Fill/drain (DEPTH=4): push PCs 0x1000,0x1004,0x1008,0x100C with ready_d=0 -> count=4, ready_f=0, 5th push ignored; then ready_d=1 -> head PCs pop in order, valid_d falls after 4 pops.
- Field extract: push inst=0x00A28293 -> next cycle rs1_d=5, constimm12_d=0x00A, inst_d=0x00A28293.
- Simultaneous push/pop at count=2 for 8 cycles with incrementing PCs -> count stays 2, output order matches input, pointers wrap correctly.
- Flush with push: count=3, flush=1 and valid_f=1 same edge -> count=0, valid_d=0, all payload 0 next cycle.
- Compressed bundle: push cinst=0x4501, cillegal=1 -> head cinst_d=0x4501, cillegal_inst_d=1; after pop to empty both read 0.
